// File: rtl/rv_core_pkg.sv
// Shared core-wide types and constants for the RISC-V fetch path.
package rv_core_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t       PC_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned PC_INC          = 4;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential increment or PC-relative jump.
module pc_next_calc
    import rv_core_pkg::*;
#(
    parameter int unsigned XLEN   = rv_core_pkg::XLEN,
    parameter int unsigned PC_INC = rv_core_pkg::PC_INC
) (
    input  logic [XLEN-1:0] pc_reg,
    input  logic            jmp,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] next_pc
);

    localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

    logic [XLEN-1:0] jump_offset;

    // Shifting left within XLEN bits keeps two's-complement sign, so negative imm steps backward.
    assign jump_offset = imm << 1;

    always_comb begin
        next_pc = pc_reg + INC;
        if (jmp) begin
            next_pc = pc_reg + jump_offset;
        end
    end

endmodule

// File: rtl/program_counter.sv
// Fetch-path PC register: reset, stall, jump, or sequential advance.
// Optional PC_ALIGN_CHECK_EN adds a registered 'misaligned' flag output.
module program_counter
    import rv_core_pkg::*;
#(
    parameter int unsigned     XLEN         = rv_core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = rv_core_pkg::PC_RESET_VECTOR,
    parameter int unsigned     PC_INC       = rv_core_pkg::PC_INC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            jmp,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc_out
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic            misaligned
`endif
);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] next_pc;

    pc_next_calc #(
        .XLEN   (XLEN),
        .PC_INC (PC_INC)
    ) u_pc_next_calc (
        .pc_reg  (pc_reg),
        .jmp     (jmp),
        .imm     (imm),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg <= RESET_VECTOR;
        end else if (en) begin
            pc_reg <= next_pc;
        end
    end

    assign pc_out = pc_reg;

`ifdef PC_ALIGN_CHECK_EN
    // Cleared to 0 on reset regardless of RESET_VECTOR alignment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            misaligned <= 1'b0;
        end else if (en) begin
            misaligned <= next_pc[1];
        end
    end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed plan plus randomized traffic.
module tb_program_counter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        jmp;
    logic [31:0] imm;
    logic [31:0] pc_out;
`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    program_counter #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .PC_INC       (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .jmp    (jmp),
        .imm    (imm),
        .pc_out (pc_out)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misaligned (misaligned)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic        mis;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          model_valid = 0;
    logic [31:0] model_pc;
    logic        model_mis;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: PC as an integer modulo 2^32, offset counted in half-words.
    task automatic step(input bit r, input bit e, input bit j, input int im, input string name);
        exp_t x;
        longint next_val;
        @(posedge clk);
        #2;
        rst = r;
        en  = e;
        jmp = j;
        imm = 32'(im);
        #1;
        if (model_valid) begin
            checks++;
            if (pc_out !== model_pc) begin
                errors++;
                $display("FAIL %s/no_early_update: pc_out=%h required=%h", name, pc_out, model_pc);
            end
        end
        if (!r) begin
            model_pc    = 32'h0000_0000;
            model_mis   = 1'b0;
            model_valid = 1;
        end else if (e && model_valid) begin
            if (j) next_val = longint'(model_pc) + 2 * longint'(im);
            else   next_val = longint'(model_pc) + 4;
            next_val  = next_val % 64'sd4294967296;
            if (next_val < 0) next_val += 64'sd4294967296;
            model_pc  = 32'(next_val);
            model_mis = ((next_val / 2) % 2) != 0;
        end
        if (model_valid) begin
            x.pc   = model_pc;
            x.mis  = model_mis;
            x.name = name;
            exp_q.push_back(x);
        end
    endtask

    // Monitor: the PC presents a new value after every edge; compare in order.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (pc_out !== x.pc) begin
                    errors++;
                    $display("FAIL %s/pc: pc_out=%h required=%h", x.name, pc_out, x.pc);
                end
`ifdef PC_ALIGN_CHECK_EN
                checks++;
                if (misaligned !== x.mis) begin
                    errors++;
                    $display("FAIL %s/misaligned: got=%0b required=%0b", x.name, misaligned, x.mis);
                end
`endif
            end
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b1;
        en  = 1'b0;
        jmp = 1'b0;
        imm = '0;

        step(0, 1, 0, 0,   "reset");
        step(1, 1, 0, 0,   "seq4");
        step(1, 1, 0, 0,   "seq8");
        step(1, 0, 0, 0,   "stall1");
        step(1, 0, 0, 0,   "stall2");
        step(1, 1, 1, 4,   "jmp_fwd");
        step(1, 1, 1, -2,  "jmp_back");
        step(1, 0, 1, 10,  "stall_jmp");
        step(1, 1, 1, 1,   "jmp_half1");
        step(1, 1, 1, 1,   "jmp_half2");
        step(0, 1, 0, 0,   "mid_reset");
        step(1, 1, 1, -2,  "underflow");
        step(1, 1, 0, 0,   "overflow");

        for (int i = 0; i < 400; i++) begin
            bit r, e, j;
            int im;
            r = ($urandom_range(0, 99) >= 4);
            e = ($urandom_range(0, 99) < 75);
            j = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 3) == 0) im = int'($urandom());
            else                           im = int'($urandom_range(0, 64)) - 32;
            step(r, e, j, im, "random");
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
